testport_writer: RTL and testbench

Stimulus generator that drives the CPU-side test-port write stream consumed by the result-checker testbed. On `start` it issues a framed sequence of single-word writes to the test port: the begin symbol, Fibonacci terms F(0)..F(N-1) ascending, the same terms descending, and the end symbol. It self-checks the checker and stands in for the CPU in bench-only configurations. Every write is a `wen` pulse separated by idle cycles, so the checker's one-count-per-write-edge logic sees each word exactly once; a `stall` input emulates D-cache hold.

---
 rtl/testport_if.sv | 22 ++
 rtl/testport_writer.sv | 131 +++++++++++++
 tb/tb_testport_writer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/testport_if.sv
// Test-port write stream bundle.
//   start    : launch one frame (sampled in IDLE/DONE)
//   stall    : hold the pending write (D-cache hold emulation)
//   addr     : word address, TEST_PORT while wen=1 else 0
//   data     : frame word while wen=1 else 0
//   wen      : write strobe
//   busy     : frame in progress
//   done     : frame complete, held until next start
//   wr_count : writes retired in the current frame
interface testport_if;
  logic        start;
  logic        stall;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        busy;
  logic        done;
  logic [5:0]  wr_count;

  modport master (input start, stall, output addr, data, wen, busy, done, wr_count);
  modport slave  (output start, stall, input addr, data, wen, busy, done, wr_count);
endinterface

// File: rtl/testport_writer.sv
// testport_writer: emits a framed write stream on the test port.
// Frame: BEGIN_SYMBOL, F(0)..F(N-1), F(N-1)..F(0), END_SYMBOL.
// Each write is a one-cycle wen pulse (held while stall=1), followed by
// GAP idle cycles, except the END write which goes straight to DONE.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   tp  : testport_if.master (start/stall in; addr/data/wen/busy/done/wr_count out)
module testport_writer #(
  parameter logic [29:0] TEST_PORT    = 30'h40,
  parameter logic [31:0] BEGIN_SYMBOL = 32'h00000932,
  parameter logic [31:0] END_SYMBOL   = 32'h00000D5D,
  parameter int          N            = 16,
  parameter int          GAP          = 1
) (
  input  logic          clk,
  input  logic          rst,
  testport_if.master    tp
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BEGIN = 3'd1;
  localparam logic [2:0] S_ASC   = 3'd2;
  localparam logic [2:0] S_DESC  = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // r_state advances at retirement, so during a GAP phase it already names
  // the state whose word is emitted when the gap expires.
  logic [2:0]  r_state;
  logic        r_wr;        // 1 = WR phase, 0 = GAP phase (or IDLE/DONE)
  logic [3:0]  r_gcnt;
  logic [4:0]  r_idx;       // writes retired in the current ASC/DESC half
  logic [31:0] r_cur;
  logic [31:0] r_prev;
  logic [29:0] r_addr;
  logic [31:0] r_data;
  logic        r_wen;
  logic        r_busy;
  logic        r_done;
  logic [5:0]  r_wr_count;

  logic w_active;
  logic w_retire;
  logic w_gap_end;
  logic w_last_term;

  assign w_active    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_retire    = w_active && r_wr && !tp.stall;
  assign w_gap_end   = w_active && !r_wr && (r_gcnt == 4'(GAP - 1));
  assign w_last_term = (r_idx == 5'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr       <= 1'b0;
      r_gcnt     <= '0;
      r_idx      <= '0;
      r_cur      <= '0;
      r_prev     <= 32'd1;
      r_addr     <= '0;
      r_data     <= '0;
      r_wen      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_count <= '0;
    end else if (!w_active) begin
      if (tp.start) begin
        r_state    <= S_BEGIN;
        r_wr       <= 1'b1;
        r_gcnt     <= '0;
        r_idx      <= '0;
        r_cur      <= '0;
        r_prev     <= 32'd1;
        r_addr     <= TEST_PORT;
        r_data     <= BEGIN_SYMBOL;
        r_wen      <= 1'b1;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
        r_wr_count <= '0;
      end
    end else if (w_retire) begin
      r_wr       <= 1'b0;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_gcnt     <= '0;
      r_wr_count <= r_wr_count + 6'd1;
      case (r_state)
        S_BEGIN: r_state <= S_ASC;
        S_ASC: begin
          // F(N-1) is left in cur so DESC starts by repeating it
          if (w_last_term) begin
            r_state <= S_DESC;
            r_idx   <= '0;
          end else begin
            r_prev <= r_cur;
            r_cur  <= r_cur + r_prev;
            r_idx  <= r_idx + 5'd1;
          end
        end
        S_DESC: begin
          r_cur  <= r_prev;
          r_prev <= r_cur - r_prev;
          if (w_last_term) r_state <= S_END;
          else             r_idx   <= r_idx + 5'd1;
        end
        S_END: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end else if (w_gap_end) begin
      r_wr   <= 1'b1;
      r_wen  <= 1'b1;
      r_addr <= TEST_PORT;
      r_data <= (r_state == S_END) ? END_SYMBOL : r_cur;
      r_gcnt <= '0;
    end else if (!r_wr) begin
      r_gcnt <= r_gcnt + 4'd1;
    end
  end

  assign tp.addr     = r_addr;
  assign tp.data     = r_data;
  assign tp.wen      = r_wen;
  assign tp.busy     = r_busy;
  assign tp.done     = r_done;
  assign tp.wr_count = r_wr_count;
endmodule

// File: tb/tb_testport_writer.sv
module tb_testport_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  testport_if ifa();
  testport_if ifb();

  testport_writer #(.N(16), .GAP(1)) dut_a (.clk(clk), .rst(rst), .tp(ifa.master));
  testport_writer #(.N(1),  .GAP(3)) dut_b (.clk(clk), .rst(rst), .tp(ifb.master));

  int sel = 0;
  logic        s_wen, s_busy, s_done;
  logic [29:0] s_addr;
  logic [31:0] s_data;
  logic [5:0]  s_wrc;
  assign s_wen  = (sel != 0) ? ifb.wen      : ifa.wen;
  assign s_busy = (sel != 0) ? ifb.busy     : ifa.busy;
  assign s_done = (sel != 0) ? ifb.done     : ifa.done;
  assign s_addr = (sel != 0) ? ifb.addr     : ifa.addr;
  assign s_data = (sel != 0) ? ifb.data     : ifa.data;
  assign s_wrc  = (sel != 0) ? ifb.wr_count : ifa.wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // Reference model: a frame is a list of words; each word is written until
  // a stall-free edge, then GAP idle cycles follow (none after the last).
  logic [31:0] m_words[$];
  int m_n, m_gap;
  int m_ph;   // 0 idle, 1 writing, 2 gap, 3 done
  int m_k, m_g, m_wrc;
  logic m_busy, m_done;

  task automatic model_cfg(input int s);
    logic [31:0] fib[30];
    sel   = s;
    m_n   = (s != 0) ? 1 : 16;
    m_gap = (s != 0) ? 3 : 1;
    fib[0] = 0; fib[1] = 1;
    for (int i = 2; i < 30; i++) fib[i] = fib[i-1] + fib[i-2];
    m_words = {};
    m_words.push_back(32'h932);
    for (int i = 0; i < m_n; i++) m_words.push_back(fib[i]);
    for (int i = m_n - 1; i >= 0; i--) m_words.push_back(fib[i]);
    m_words.push_back(32'hD5D);
  endtask

  task automatic model_reset();
    m_ph = 0; m_k = 0; m_g = 0; m_wrc = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_edge(input logic st, input logic sl);
    case (m_ph)
      0, 3: if (st) begin m_ph = 1; m_k = 0; m_wrc = 0; m_busy = 1; m_done = 0; end
      1: if (!sl) begin
        m_wrc++;
        if (m_k == m_words.size() - 1) begin m_ph = 3; m_busy = 0; m_done = 1; end
        else begin m_ph = 2; m_g = 0; end
      end
      2: begin m_g++; if (m_g == m_gap) begin m_ph = 1; m_k++; end end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    logic w;
    w = (m_ph == 1);
    chk("wen",      {31'd0, s_wen},  {31'd0, w});
    chk("addr",     {2'd0, s_addr},  w ? 32'h40 : 32'd0);
    chk("data",     s_data,          w ? m_words[m_k] : 32'd0);
    chk("busy",     {31'd0, s_busy}, {31'd0, m_busy});
    chk("done",     {31'd0, s_done}, {31'd0, m_done});
    chk("wr_count", {26'd0, s_wrc},  32'(m_wrc));
  endtask

  task automatic drive(input logic st, input logic sl);
    ifa.start = (sel == 0) ? st : 1'b0;
    ifa.stall = (sel == 0) ? sl : 1'b0;
    ifb.start = (sel != 0) ? st : 1'b0;
    ifb.stall = (sel != 0) ? sl : 1'b0;
  endtask

  task automatic step(input logic st, input logic sl);
    drive(st, sl);
    @(posedge clk);
    model_edge(st, sl);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    drive(0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  // mode 0: clean; 1: random stall/start; 2: 5-cycle stall on word 144
  task automatic run_frame(input int mode, output int done_cyc);
    int c;
    int sleft;
    logic st, sl;
    sleft = 5;
    done_cyc = -1;
    step(1, 0);
    c = 1;
    while (c < 2000 && m_ph != 3) begin
      st = 0; sl = 0;
      if (mode == 1) begin
        sl = ($urandom_range(0, 3) == 0);
        st = ($urandom_range(0, 9) == 0);
      end
      if (mode == 2 && s_wen && s_data == 32'd144 && sleft > 0) begin
        sl = 1; sleft--;
      end
      step(st, sl);
      c++;
      if (s_done && done_cyc < 0) done_cyc = c;
    end
    step(0, 0);
    chk("final_wr_count", {26'd0, s_wrc}, 32'(2 * m_n + 2));
  endtask

  typedef struct {
    logic        st, sl;
    logic        wen;
    logic [31:0] data;
    logic        busy, done;
    logic [5:0]  wrc;
  } vec_t;

  initial begin
    vec_t tbl[10];
    int dc;
    int k;
    drive(0, 0);
    model_cfg(0);
    model_reset();
    #2;
    // reset state is visible while rst is still held
    compare_all();
    do_reset();

    tbl[0] = '{1, 0, 1, 32'h932, 1, 0, 6'd0};
    tbl[1] = '{0, 0, 0, 32'd0,   1, 0, 6'd1};
    tbl[2] = '{0, 0, 1, 32'd0,   1, 0, 6'd1};
    tbl[3] = '{0, 0, 0, 32'd0,   1, 0, 6'd2};
    tbl[4] = '{0, 1, 1, 32'd1,   1, 0, 6'd2};
    tbl[5] = '{0, 1, 1, 32'd1,   1, 0, 6'd2};
    tbl[6] = '{0, 0, 0, 32'd0,   1, 0, 6'd3};
    tbl[7] = '{1, 0, 1, 32'd1,   1, 0, 6'd3};
    tbl[8] = '{0, 0, 0, 32'd0,   1, 0, 6'd4};
    tbl[9] = '{0, 0, 1, 32'd2,   1, 0, 6'd4};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].st, tbl[i].sl);
      @(posedge clk); #1;
      chk("tbl_wen",  {31'd0, s_wen},  {31'd0, tbl[i].wen});
      chk("tbl_data", s_data,          tbl[i].data);
      chk("tbl_busy", {31'd0, s_busy}, {31'd0, tbl[i].busy});
      chk("tbl_done", {31'd0, s_done}, {31'd0, tbl[i].done});
      chk("tbl_wrc",  {26'd0, s_wrc},  {26'd0, tbl[i].wrc});
    end

    // nominal frame, then restart from DONE
    do_reset();
    run_frame(0, dc);
    chk("nominal_done_cycle", 32'(dc), 32'd68);
    run_frame(0, dc);
    chk("restart_done_cycle", 32'(dc), 32'd68);

    // stall on the word 144
    do_reset();
    run_frame(2, dc);
    chk("stall_done_cycle", 32'(dc), 32'd73);

    // reset in the middle of the write of 89
    do_reset();
    step(1, 0);
    k = 0;
    while (k < 200 && !(s_wen && s_data == 32'd89)) begin step(0, 0); k++; end
    chk("found_89", {31'd0, s_wen && s_data == 32'd89}, 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    rst = 1'b0;
    compare_all();
    run_frame(0, dc);
    chk("post_reset_done_cycle", 32'(dc), 32'd68);

    // random stall/start pressure, frames chained through DONE
    for (int r = 0; r < 4; r++) run_frame(1, dc);

    // boundary N=1, GAP=3
    model_cfg(1);
    do_reset();
    run_frame(0, dc);
    chk("n1_done_cycle", 32'(dc), 32'd14);
    for (int r = 0; r < 3; r++) run_frame(1, dc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
